// File: rtl/adder.sv
// adder: unsigned WIDTH+1-bit sum of two operands plus a one-cycle registered copy with carry/zero flags.
// Define ADDER_CLA_EN for 4-bit carry-lookahead groups; the default build is a ripple chain of full-adder cells.

module adder_fa (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);
   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));
endmodule

module adder #(
   parameter int WIDTH = 4
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic [WIDTH-1:0] OperandoA,
   input  logic [WIDTH-1:0] OperandoB,
   output logic [WIDTH:0]   Soma,
   output logic [WIDTH:0]   SomaReg,
   output logic             CarryReg,
   output logic             ZeroReg
);
   genvar gi;
   genvar gk;

`ifdef ADDER_CLA_EN
   localparam int NGRP    = (WIDTH + 3) / 4;
   localparam int LAST_NB = WIDTH - (NGRP - 1) * 4;

   // Carry out of bit n of a group as a flat sum of products, so every carry
   // in the group depends only on g/p and the group carry-in.
   function automatic logic group_carry(input logic [3:0] g, input logic [3:0] p,
                                        input logic cin, input int n);
      logic term;
      logic acc;
      acc = 1'b0;
      for (int j = 0; j <= n; j++) begin
         term = g[j];
         for (int k = j + 1; k <= n; k++) term = term & p[k];
         acc = acc | term;
      end
      term = cin;
      for (int k = 0; k <= n; k++) term = term & p[k];
      return acc | term;
   endfunction

   generate
      for (gi = 0; gi < NGRP; gi++) begin : g_grp
         localparam int NB = (WIDTH - gi * 4 >= 4) ? 4 : (WIDTH - gi * 4);
         logic [3:0]  gpad;
         logic [3:0]  ppad;
         logic [NB:0] c;

         if (gi == 0) begin : g_cin0
            assign c[0] = 1'b0;
         end else begin : g_cinn
            assign c[0] = g_grp[gi-1].c[4];
         end

         // Bits past WIDTH in a partial top group generate and propagate nothing.
         for (gk = 0; gk < 4; gk++) begin : g_gp
            if (gk < NB) begin : g_live
               assign gpad[gk] = OperandoA[gi*4+gk] & OperandoB[gi*4+gk];
               assign ppad[gk] = OperandoA[gi*4+gk] ^ OperandoB[gi*4+gk];
            end else begin : g_pad
               assign gpad[gk] = 1'b0;
               assign ppad[gk] = 1'b0;
            end
         end

         for (gk = 0; gk < NB; gk++) begin : g_bit
            assign c[gk+1]       = group_carry(gpad, ppad, c[0], gk);
            assign Soma[gi*4+gk] = ppad[gk] ^ c[gk];
         end
      end
   endgenerate

   assign Soma[WIDTH] = g_grp[NGRP-1].c[LAST_NB];
`else
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_bit
         logic cin;
         logic cout;

         if (gi == 0) begin : g_cin0
            assign cin = 1'b0;
         end else begin : g_cinn
            assign cin = g_bit[gi-1].cout;
         end

         adder_fa u_fa (
            .a    (OperandoA[gi]),
            .b    (OperandoB[gi]),
            .cin  (cin),
            .sum  (Soma[gi]),
            .cout (cout)
         );
      end
   endgenerate

   assign Soma[WIDTH] = g_bit[WIDTH-1].cout;
`endif

   // Reset value keeps ZeroReg consistent with a cleared SomaReg.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         SomaReg  <= '0;
         CarryReg <= 1'b0;
         ZeroReg  <= 1'b1;
      end else begin
         SomaReg  <= Soma;
         CarryReg <= Soma[WIDTH];
         ZeroReg  <= (Soma == '0);
      end
   end
endmodule

// File: tb/tb_adder.sv
// tb_adder: exhaustive, corner, register/reset and randomized checks of adder at WIDTH 1, 4 and 8
// against plain integer arithmetic.

module tb_adder;
   logic       clk;
   logic       rst;

   logic [3:0] a4, b4;
   logic [4:0] s4, sr4;
   logic       c4, z4;

   logic [0:0] a1, b1;
   logic [1:0] s1, sr1;
   logic       c1, z1;

   logic [7:0] a8, b8;
   logic [8:0] s8, sr8;
   logic       c8, z8;

   int checks = 0;
   int errors = 0;

   adder #(.WIDTH(4)) dut (
      .Clock(clk), .Reset(rst), .OperandoA(a4), .OperandoB(b4),
      .Soma(s4), .SomaReg(sr4), .CarryReg(c4), .ZeroReg(z4)
   );

   adder #(.WIDTH(1)) dut_w1 (
      .Clock(clk), .Reset(rst), .OperandoA(a1), .OperandoB(b1),
      .Soma(s1), .SomaReg(sr1), .CarryReg(c1), .ZeroReg(z1)
   );

   adder #(.WIDTH(8)) dut_w8 (
      .Clock(clk), .Reset(rst), .OperandoA(a8), .OperandoB(b8),
      .Soma(s8), .SomaReg(sr8), .CarryReg(c8), .ZeroReg(z8)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=%0d required=%0d", tag, obs, exp);
      end
   endtask

   // Expected registered state of the WIDTH=4 instance holding sum 'sum'.
   task automatic check_reg4(input string tag, input int sum);
      check({tag, "_somareg"}, 32'(sr4), 32'(sum));
      check({tag, "_carryreg"}, 32'(c4), 32'(sum >= 16));
      check({tag, "_zeroreg"}, 32'(z4), 32'(sum == 0));
   endtask

   int corner_a[4] = '{0, 15, 15, 8};
   int corner_b[4] = '{0, 15, 1, 7};
   int corner_s[4] = '{0, 30, 16, 15};
   int corner_m[4] = '{0, 1, 1, 0};

   initial begin
      clk = 1'b0;
      rst = 1'b1;
      a4 = 4'd3; b4 = 4'd4;
      a1 = 1'b1; b1 = 1'b1;
      a8 = 8'd200; b8 = 8'd100;

      // Reset state, with the combinational sum still live.
      #1;
      $display("txn reset a=3 b=4 soma=%0d somareg=%0d", s4, sr4);
      check("reset_soma4", 32'(s4), 32'd7);
      check_reg4("reset", 0);
      check("reset_soma1", 32'(s1), 32'd2);
      check("reset_soma8", 32'(s8), 32'd300);
      check("reset_somareg8", 32'(sr8), 32'd0);
      check("reset_zeroreg1", 32'(z1), 32'd1);

      @(negedge clk);
      rst = 1'b0;

      // Exhaustive WIDTH=4 sweep.
      for (int i = 0; i < 16; i++) begin
         for (int j = 0; j < 16; j++) begin
            a4 = 4'(i); b4 = 4'(j);
            #5;
            $display("txn sweep %0d+%0d soma=%0d", i, j, s4);
            check("sweep_soma", 32'(s4), 32'(i + j));
         end
      end

      for (int k = 0; k < 4; k++) begin
         a4 = 4'(corner_a[k]); b4 = 4'(corner_b[k]);
         #5;
         $display("txn corner %0d+%0d soma=%0d", corner_a[k], corner_b[k], s4);
         check("corner_soma", 32'(s4), 32'(corner_s[k]));
         check("corner_msb", 32'(s4[4]), 32'(corner_m[k]));
      end

      // Register latency: 5+6 captured, then 9+9 must wait for the next edge.
      @(negedge clk);
      a4 = 4'd5; b4 = 4'd6;
      @(posedge clk); #1;
      $display("txn reg 5+6 somareg=%0d", sr4);
      check_reg4("lat_first", 11);
      @(negedge clk);
      a4 = 4'd9; b4 = 4'd9;
      #1;
      $display("txn reg 9+9 before edge somareg=%0d", sr4);
      check_reg4("lat_hold", 11);
      @(posedge clk); #1;
      $display("txn reg 9+9 after edge somareg=%0d", sr4);
      check_reg4("lat_capture", 18);

      // Asynchronous reset between edges.
      #2;
      rst = 1'b1;
      #1;
      $display("txn midreset somareg=%0d soma=%0d", sr4, s4);
      check_reg4("midrst", 0);
      check("midrst_soma", 32'(s4), 32'd18);
      @(posedge clk); #1;
      check_reg4("midrst_edge", 0);
      @(negedge clk);
      rst = 1'b0;
      a4 = 4'd2; b4 = 4'd3;
      @(posedge clk); #1;
      $display("txn release 2+3 somareg=%0d", sr4);
      check_reg4("release", 5);
      @(negedge clk);
      a4 = 4'd0; b4 = 4'd0;
      @(posedge clk); #1;
      check_reg4("zero_capture", 0);

      // Randomized vectors on all three widths, combinational then registered.
      for (int n = 0; n < 1000; n++) begin
         int e1, e4, e8;
         @(negedge clk);
         a1 = 1'($urandom); b1 = 1'($urandom);
         a4 = 4'($urandom); b4 = 4'($urandom);
         a8 = 8'($urandom); b8 = 8'($urandom);
         e1 = int'(a1) + int'(b1);
         e4 = int'(a4) + int'(b4);
         e8 = int'(a8) + int'(b8);
         #1;
         $display("txn rand %0d w1 %0d+%0d=%0d w4 %0d+%0d=%0d w8 %0d+%0d=%0d",
                  n, a1, b1, s1, a4, b4, s4, a8, b8, s8);
         check("rand_soma1", 32'(s1), 32'(e1));
         check("rand_soma4", 32'(s4), 32'(e4));
         check("rand_soma8", 32'(s8), 32'(e8));
         @(posedge clk); #1;
         check_reg4("rand4", e4);
         check("rand_somareg1", 32'(sr1), 32'(e1));
         check("rand_carryreg1", 32'(c1), 32'(e1 >= 2));
         check("rand_zeroreg1", 32'(z1), 32'(e1 == 0));
         check("rand_somareg8", 32'(sr8), 32'(e8));
         check("rand_carryreg8", 32'(c8), 32'(e8 >= 256));
         check("rand_zeroreg8", 32'(z8), 32'(e8 == 0));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/adder.md
# adder

Unsigned two-operand adder used as the partial-product accumulation primitive of the multiplier datapath. It adds two WIDTH-bit operands and produces a WIDTH+1-bit sum combinationally, with no truncation. It also provides a one-cycle registered copy of the sum and its flags for pipelined consumers. Stateless apart from the output register stage.

## Interface

- WIDTH, default 4, operand width in bits (legal range 1..32).

- Clock  input  1  rising-edge clock for the registered outputs.
- Reset  input  1  asynchronous, active-high; clears the registered outputs.
- OperandoA  input  WIDTH  unsigned operand A.
- OperandoB  input  WIDTH  unsigned operand B.
- Soma  output  WIDTH+1  combinational sum OperandoA + OperandoB; MSB is carry-out.
- SomaReg  output  WIDTH+1  Soma sampled at the last rising Clock edge.
- CarryReg  output  1  equals SomaReg[WIDTH].
- ZeroReg  output  1  high when SomaReg == 0.

## Operation

- Soma = zero-extended OperandoA + zero-extended OperandoB; never wraps, never saturates.
  - WIDTH=4 range: 0..30.
- Soma is purely combinational.
  - No dependence on Clock or Reset.
  - Valid even while Reset is asserted or when Clock is not toggling.
- Adder is built from one-bit full-adder cells (sum = a^b^cin, cout = ab | cin(a^b)), instantiated per bit with a generate loop.
  - Carry-in of bit 0 is 0.
  - Carry-out of bit WIDTH-1 drives Soma[WIDTH].
- Register stage:
  - On each rising Clock edge with Reset low: SomaReg <= Soma, CarryReg <= Soma[WIDTH], ZeroReg <= (Soma == 0).
  - No enable; the register updates every cycle.
- Reset, asynchronous, takes effect immediately on assertion:
  - SomaReg = 0, CarryReg = 0, ZeroReg = 1, so the flags stay consistent with SomaReg.
- Release of Reset: the first capture occurs at the first rising Clock edge with Reset low.
- X/Z on operands propagates to Soma; no X-masking.

## Timing

- Soma: zero cycles latency.
  - Must settle within 5 ns of an operand change at WIDTH=4.
  - Operands may change every 5 ns with no clock present.
- SomaReg/CarryReg/ZeroReg: one-cycle latency.
  - Operands present before edge N appear on the registered outputs after edge N.
- Operands changing in the same delta as the Clock edge: the value present before the edge is captured (standard setup semantics).
- Reset asserted mid-stream: registered outputs go to reset values within the same time step and hold until the first edge after deassertion. Soma is unaffected.

## Configuration

- ADDER_CLA_EN defined:
  - Carry chain uses 4-bit carry-lookahead groups: generate/propagate per bit, group carry computed in parallel, ripple between groups.
  - A partial top group is handled by the same equations.
- ADDER_CLA_EN undefined: plain ripple-carry chain of full-adder cells.
- Functional results on every port are identical in both builds. Only structure and combinational depth differ.

## Test plan

- Exhaustive: WIDTH=4, OperandoA and OperandoB each swept 0..15 (nested loops, 5 ns per vector, no clock) -> Soma == i+j for all 256 pairs.
- Corners: 0+0 -> Soma=0; 15+15 -> Soma=30 (5'b11110); 15+1 -> Soma=16, MSB set; 8+7 -> Soma=15, MSB clear.
- Register latency: apply 9+9 before edge N -> after edge N, SomaReg=18, CarryReg=1, ZeroReg=0; prior values hold before edge N.
- Reset mid-operation: SomaReg=18, assert Reset between edges -> SomaReg=0, CarryReg=0, ZeroReg=1 immediately, while Soma still shows 18. After release, the next edge captures the current sum.
- Build variants: rerun the exhaustive sweep with and without ADDER_CLA_EN, and at WIDTH=1 and WIDTH=8 (random 1000 vectors) -> identical, correct sums.
